// File: rtl/order_book_scan_if.sv
// Command/response and top-of-book bundle between the feed decoder, the order
// book and the strategy block.
interface order_book_scan_if #(
  parameter int NUM_STOCKS = 4,
  parameter int PRICE_W    = 32,
  parameter int QTY_W      = 16,
  parameter int ID_W       = 32
);
  localparam int SID_W = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;

  logic                          i_cmd_valid;
  logic                          o_cmd_ready;
  logic [1:0]                    i_cmd_op;
  logic                          i_cmd_side;
  logic [SID_W-1:0]              i_cmd_stock;
  logic [ID_W-1:0]               i_cmd_id;
  logic [PRICE_W-1:0]            i_cmd_price;
  logic [QTY_W-1:0]              i_cmd_qty;
  logic                          o_resp_valid;
  logic [1:0]                    o_resp_status;
  logic [QTY_W-1:0]              o_resp_qty;
  logic [NUM_STOCKS*PRICE_W-1:0] o_best_bid;
  logic [NUM_STOCKS*PRICE_W-1:0] o_best_ask;

  modport slave (
    input  i_cmd_valid, i_cmd_op, i_cmd_side, i_cmd_stock, i_cmd_id, i_cmd_price, i_cmd_qty,
    output o_cmd_ready, o_resp_valid, o_resp_status, o_resp_qty, o_best_bid, o_best_ask
  );

  modport master (
    output i_cmd_valid, i_cmd_op, i_cmd_side, i_cmd_stock, i_cmd_id, i_cmd_price, i_cmd_qty,
    input  o_cmd_ready, o_resp_valid, o_resp_status, o_resp_qty, o_best_bid, o_best_ask
  );
endinterface

// File: rtl/order_book_scan.sv
// Slot-array order book: serial search, one-cycle apply, serial rescan of the
// touched (stock, side) and registered top-of-book per stock.
module order_book_scan #(
  parameter int NUM_STOCKS = 4,
  parameter int DEPTH      = 16,
  parameter int PRICE_W    = 32,
  parameter int QTY_W      = 16,
  parameter int ID_W       = 32
) (
  input logic             i_clk,
  input logic             i_reset_n,
  order_book_scan_if.slave bus
);
  localparam int SID_W = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] OP_ADD    = 2'd0;
  localparam logic [1:0] OP_CANCEL = 2'd1;
  localparam logic [1:0] OP_EXEC   = 2'd2;

  typedef enum logic [1:0] {RS_OK, RS_FULL, RS_NOT_FOUND, RS_DUP_ID} rsp_t;
  typedef enum logic [2:0] {S_IDLE, S_SEARCH, S_APPLY, S_RESCAN, S_RESP} state_t;

  state_t state;

  logic [NUM_STOCKS-1:0][1:0][DEPTH-1:0] slot_vld;
  logic [ID_W-1:0]    slot_id    [NUM_STOCKS][2][DEPTH];
  logic [PRICE_W-1:0] slot_price [NUM_STOCKS][2][DEPTH];
  logic [QTY_W-1:0]   slot_qty   [NUM_STOCKS][2][DEPTH];

  logic [1:0]         c_op;
  logic               c_side;
  logic [SID_W-1:0]   c_stk;
  logic [ID_W-1:0]    c_id;
  logic [PRICE_W-1:0] c_price;
  logic [QTY_W-1:0]   c_qty;

  logic [IDX_W-1:0]   idx, hit_idx, free_idx;
  logic               hit, free;
  logic [PRICE_W-1:0] scan_acc, scan_next;
  rsp_t               res_status;
  logic [QTY_W-1:0]   res_qty;

  logic                                ready_q, resp_valid_q;
  logic [1:0]                          resp_status_q;
  logic [QTY_W-1:0]                    resp_qty_q;
  logic [NUM_STOCKS-1:0][PRICE_W-1:0]  bid_q, ask_q;

  assign bus.o_cmd_ready   = ready_q;
  assign bus.o_resp_valid  = resp_valid_q;
  assign bus.o_resp_status = resp_status_q;
  assign bus.o_resp_qty    = resp_qty_q;
  assign bus.o_best_bid    = bid_q;
  assign bus.o_best_ask    = ask_q;

  wire accept = bus.i_cmd_valid && ready_q;
  wire last   = (idx == IDX_W'(DEPTH - 1));

  wire               cur_v     = slot_vld[c_stk][c_side][idx];
  wire [ID_W-1:0]    cur_id    = slot_id[c_stk][c_side][idx];
  wire [PRICE_W-1:0] cur_price = slot_price[c_stk][c_side][idx];

  // Buy side tracks the max valid price, sell side the min.
  always_comb begin
    scan_next = scan_acc;
    if (cur_v && (c_side ? (cur_price > scan_acc) : (cur_price < scan_acc)))
      scan_next = cur_price;
  end

  wire [QTY_W-1:0] stored = slot_qty[c_stk][c_side][hit_idx];
  wire [QTY_W-1:0] fill   = (c_qty < stored) ? c_qty : stored;

  rsp_t            ap_status;
  logic [QTY_W-1:0] ap_qty;
  logic            ap_add, ap_clr, ap_upd;

  always_comb begin
    ap_status = RS_OK;
    ap_qty    = '0;
    ap_add    = 1'b0;
    ap_clr    = 1'b0;
    ap_upd    = 1'b0;
    case (c_op)
      OP_ADD: begin
        if (hit)        ap_status = RS_DUP_ID;
        else if (!free) ap_status = RS_FULL;
        else begin
          ap_add = 1'b1;
          ap_qty = c_qty;
        end
      end
      OP_CANCEL: begin
        if (!hit) ap_status = RS_NOT_FOUND;
        else begin
          ap_clr = 1'b1;
          ap_qty = stored;
        end
      end
      OP_EXEC: begin
        if (!hit) ap_status = RS_NOT_FOUND;
        else if (c_qty != '0) begin
          ap_qty = fill;
          if (fill == stored) ap_clr = 1'b1;
          else                ap_upd = 1'b1;
        end
      end
      default: ap_status = RS_NOT_FOUND;
    endcase
  end

  // Slot payload needs no reset; only the valid bits define book contents.
  always_ff @(posedge i_clk) begin
    if (state == S_APPLY) begin
      if (ap_add) begin
        slot_id[c_stk][c_side][free_idx]    <= c_id;
        slot_price[c_stk][c_side][free_idx] <= c_price;
        slot_qty[c_stk][c_side][free_idx]   <= c_qty;
      end else if (ap_upd) begin
        slot_qty[c_stk][c_side][hit_idx] <= stored - fill;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state         <= S_IDLE;
      ready_q       <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_status_q <= '0;
      resp_qty_q    <= '0;
      bid_q         <= '0;
      ask_q         <= '1;
      slot_vld      <= '0;
      idx           <= '0;
      hit           <= 1'b0;
      free          <= 1'b0;
      hit_idx       <= '0;
      free_idx      <= '0;
      scan_acc      <= '0;
      res_status    <= RS_OK;
      res_qty       <= '0;
      c_op          <= '0;
      c_side        <= 1'b0;
      c_stk         <= '0;
      c_id          <= '0;
      c_price       <= '0;
      c_qty         <= '0;
    end else begin
      case (state)
        S_IDLE, S_RESP: begin
          resp_valid_q <= 1'b0;
          if (accept) begin
            state   <= S_SEARCH;
            ready_q <= 1'b0;
            c_op    <= bus.i_cmd_op;
            c_side  <= bus.i_cmd_side;
            c_stk   <= bus.i_cmd_stock;
            c_id    <= bus.i_cmd_id;
            c_price <= bus.i_cmd_price;
            c_qty   <= bus.i_cmd_qty;
            idx     <= '0;
            hit     <= 1'b0;
            free    <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SEARCH: begin
          if (cur_v && (cur_id == c_id) && !hit) begin
            hit     <= 1'b1;
            hit_idx <= idx;
          end
          if (!cur_v && !free) begin
            free     <= 1'b1;
            free_idx <= idx;
          end
          idx <= last ? '0 : idx + 1'b1;
          if (last) state <= S_APPLY;
        end
        S_APPLY: begin
          if (ap_add) slot_vld[c_stk][c_side][free_idx] <= 1'b1;
          if (ap_clr) slot_vld[c_stk][c_side][hit_idx]  <= 1'b0;
          res_status <= ap_status;
          res_qty    <= ap_qty;
          scan_acc   <= {PRICE_W{~c_side}};
          idx        <= '0;
          state      <= S_RESCAN;
        end
        S_RESCAN: begin
          scan_acc <= scan_next;
          idx      <= last ? '0 : idx + 1'b1;
          if (last) begin
            state         <= S_RESP;
            ready_q       <= 1'b1;
            resp_valid_q  <= 1'b1;
            resp_status_q <= res_status;
            resp_qty_q    <= res_qty;
            if (c_side) bid_q[c_stk] <= scan_next;
            else        ask_q[c_stk] <= scan_next;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_order_book_scan.sv
// Randomized and directed bench for order_book_scan against a per-slot book model.
module tb_order_book_scan;
  localparam int NS = 4, D = 16, PW = 32, QW = 16, IW = 32, SW = 2;
  localparam logic [PW-1:0] ONES = '1;

  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;

  order_book_scan_if #(.NUM_STOCKS(NS), .PRICE_W(PW), .QTY_W(QW), .ID_W(IW)) bus ();

  order_book_scan #(.NUM_STOCKS(NS), .DEPTH(D), .PRICE_W(PW), .QTY_W(QW), .ID_W(IW)) dut (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .bus      (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Book model: each (stock, side) is DEPTH slots, new orders take the lowest free slot.
  bit            m_v  [NS][2][D];
  logic [IW-1:0] m_id [NS][2][D];
  logic [PW-1:0] m_pr [NS][2][D];
  logic [QW-1:0] m_q  [NS][2][D];

  function automatic logic [PW-1:0] m_bid(input int s);
    logic [PW-1:0] r = '0;
    for (int i = 0; i < D; i++) if (m_v[s][1][i] && m_pr[s][1][i] > r) r = m_pr[s][1][i];
    return r;
  endfunction

  function automatic logic [PW-1:0] m_ask(input int s);
    logic [PW-1:0] r = ONES;
    for (int i = 0; i < D; i++) if (m_v[s][0][i] && m_pr[s][0][i] < r) r = m_pr[s][0][i];
    return r;
  endfunction

  task automatic m_clear();
    for (int s = 0; s < NS; s++) for (int d = 0; d < 2; d++) for (int i = 0; i < D; i++) m_v[s][d][i] = 0;
  endtask

  task automatic m_apply(input int op, input int sd, input int s, input logic [IW-1:0] id,
                         input logic [PW-1:0] pr, input logic [QW-1:0] q,
                         output int st, output logic [QW-1:0] rq);
    int h = -1, f = -1;
    logic [QW-1:0] fl;
    for (int i = 0; i < D; i++) begin
      if (m_v[s][sd][i] && m_id[s][sd][i] == id && h < 0) h = i;
      if (!m_v[s][sd][i] && f < 0) f = i;
    end
    st = 0; rq = '0;
    case (op)
      0: if (h >= 0) st = 3;
         else if (f < 0) st = 1;
         else begin
           m_v[s][sd][f] = 1; m_id[s][sd][f] = id; m_pr[s][sd][f] = pr; m_q[s][sd][f] = q; rq = q;
         end
      1: if (h < 0) st = 2;
         else begin rq = m_q[s][sd][h]; m_v[s][sd][h] = 0; end
      2: if (h < 0) st = 2;
         else if (q != 0) begin
           fl = (q < m_q[s][sd][h]) ? q : m_q[s][sd][h];
           rq = fl;
           m_q[s][sd][h] = m_q[s][sd][h] - fl;
           if (m_q[s][sd][h] == 0) m_v[s][sd][h] = 0;
         end
      default: st = 2;
    endcase
  endtask

  task automatic chk_books(input string tag);
    for (int s = 0; s < NS; s++) begin
      chk($sformatf("%s_bid%0d", tag, s), bus.o_best_bid[s*PW +: PW], m_bid(s));
      chk($sformatf("%s_ask%0d", tag, s), bus.o_best_ask[s*PW +: PW], m_ask(s));
    end
  endtask

  task automatic drive(input int op, input int sd, input int s, input logic [IW-1:0] id,
                       input logic [PW-1:0] pr, input logic [QW-1:0] q);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_op    = 2'(op);
    bus.i_cmd_side  = sd[0];
    bus.i_cmd_stock = SW'(s);
    bus.i_cmd_id    = id;
    bus.i_cmd_price = pr;
    bus.i_cmd_qty   = q;
  endtask

  task automatic scramble();
    bus.i_cmd_op    = 2'($urandom);
    bus.i_cmd_side  = 1'($urandom);
    bus.i_cmd_stock = SW'($urandom);
    bus.i_cmd_id    = $urandom;
    bus.i_cmd_price = $urandom;
    bus.i_cmd_qty   = QW'($urandom);
  endtask

  // Issue one command (called #1 after an edge with the block idle or in RESP).
  task automatic do_cmd(input int op, input int sd, input int s, input logic [IW-1:0] id,
                        input logic [PW-1:0] pr, input logic [QW-1:0] q);
    int est, cyc;
    logic [QW-1:0] eq;
    logic [PW-1:0] pre_b, pre_a;
    chk("ready_issue", bus.o_cmd_ready, 1);
    drive(op, sd, s, id, pr, q);
    pre_b = m_bid(s);
    pre_a = m_ask(s);
    m_apply(op, sd, s, id, pr, q, est, eq);
    @(posedge i_clk); #1;
    bus.i_cmd_valid = 1'b0;
    scramble();
    chk("resp_pulse_end", bus.o_resp_valid, 0);
    cyc = 0;
    while (cyc < 200) begin
      @(posedge i_clk); #1;
      cyc++;
      if (bus.o_resp_valid) break;
      if (cyc == 1) chk("ready_busy", bus.o_cmd_ready, 0);
      if (cyc == 2*D) begin
        chk("bid_hold", bus.o_best_bid[s*PW +: PW], pre_b);
        chk("ask_hold", bus.o_best_ask[s*PW +: PW], pre_a);
      end
    end
    chk("latency", cyc, 2*D+1);
    chk("status", bus.o_resp_status, est);
    chk("resp_qty", bus.o_resp_qty, eq);
    chk_books("post");
  endtask

  // Three commands with valid held high throughout.
  task automatic burst();
    int bop[3] = '{0, 0, 2};
    int bsd[3] = '{1, 0, 1};
    logic [PW-1:0] bpr[3] = '{50, 60, 0};
    logic [QW-1:0] bq[3]  = '{5, 3, 2};
    int est_q[$];
    logic [QW-1:0] eq_q[$];
    int k = 0, r = 0, since = -1, last_resp = -1, cyc = 0, est;
    bit exp_rdy, acc;
    logic [QW-1:0] eq;
    drive(bop[0], bsd[0], 3, 1, bpr[0], bq[0]);
    while (r < 3 && cyc < 400) begin
      exp_rdy = (since < 0) || (since >= 2*D+1);
      chk("burst_ready", bus.o_cmd_ready, exp_rdy);
      acc = exp_rdy && bus.i_cmd_valid;
      if (acc) begin
        m_apply(bop[k], bsd[k], 3, 1, bpr[k], bq[k], est, eq);
        est_q.push_back(est);
        eq_q.push_back(eq);
      end
      @(posedge i_clk); #1;
      cyc++;
      if (acc) begin
        since = 0;
        k++;
        if (k < 3) drive(bop[k], bsd[k], 3, 1, bpr[k], bq[k]);
        else bus.i_cmd_valid = 1'b0;
      end else if (since >= 0) since++;
      if (bus.o_resp_valid) begin
        r++;
        chk("burst_lat", since, 2*D+1);
        if (est_q.size() > 0) begin
          chk("burst_status", bus.o_resp_status, est_q.pop_front());
          chk("burst_qty", bus.o_resp_qty, eq_q.pop_front());
        end
        if (last_resp >= 0) chk("burst_spacing", cyc - last_resp, 2*D+2);
        last_resp = cyc;
      end
    end
    chk("burst_done", r, 3);
    chk_books("burst");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen, op, rr;
    bus.i_cmd_valid = 1'b0;
    scramble();
    m_clear();
    repeat (3) @(posedge i_clk);
    #1 i_reset_n = 1'b1;
    chk("rst_ready", bus.o_cmd_ready, 1);
    chk("rst_resp_valid", bus.o_resp_valid, 0);
    chk("rst_status", bus.o_resp_status, 0);
    chk("rst_qty", bus.o_resp_qty, 0);
    chk_books("rst");

    do_cmd(0, 1, 1, 'hA, 100, 50);
    chk("tp1_qty", bus.o_resp_qty, 50);
    chk("tp1_bid1", bus.o_best_bid[1*PW +: PW], 100);
    chk("tp1_ask1", bus.o_best_ask[1*PW +: PW], ONES);
    do_cmd(0, 1, 1, 'hB, 120, 7);
    do_cmd(0, 1, 1, 'hC, 90, 8);
    do_cmd(1, 1, 1, 'hB, 0, 0);
    chk("cancel_qty", bus.o_resp_qty, 7);
    chk("cancel_bid1", bus.o_best_bid[1*PW +: PW], 100);
    do_cmd(1, 1, 1, 'hB, 0, 0);
    chk("cancel_again", bus.o_resp_status, 2);

    do_cmd(0, 0, 2, 5, 200, 10);
    do_cmd(2, 0, 2, 5, 0, 4);
    chk("exec_fill4", bus.o_resp_qty, 4);
    do_cmd(2, 0, 2, 5, 0, 9);
    chk("exec_fill6", bus.o_resp_qty, 6);
    chk("exec_ask2", bus.o_best_ask[2*PW +: PW], ONES);

    for (int i = 0; i < D; i++) do_cmd(0, 1, 0, 100 + i, 10 + i, 1);
    do_cmd(0, 1, 0, 500, 999, 1);
    chk("full", bus.o_resp_status, 1);
    do_cmd(1, 1, 0, 103, 0, 0);
    do_cmd(0, 1, 0, 600, 5, 2);
    chk("refill_ok", bus.o_resp_status, 0);
    do_cmd(0, 1, 0, 601, 5, 2);
    chk("full_again", bus.o_resp_status, 1);
    do_cmd(0, 1, 0, 100, 7000, 3);
    chk("dup", bus.o_resp_status, 3);
    do_cmd(0, 0, 0, 100, 7000, 3);
    chk("dup_other_side", bus.o_resp_status, 0);
    do_cmd(2, 1, 0, 101, 0, 0);
    do_cmd(3, 1, 0, 101, 0, 0);

    burst();

    // Reset while the rescan is running: no response, empty books afterwards.
    drive(0, 1, 0, 777, 5, 1);
    @(posedge i_clk); #1;
    bus.i_cmd_valid = 1'b0;
    seen = 0;
    repeat (D + 4) begin @(posedge i_clk); #1; if (bus.o_resp_valid) seen++; end
    i_reset_n = 1'b0;
    repeat (2) begin @(posedge i_clk); #1; if (bus.o_resp_valid) seen++; end
    i_reset_n = 1'b1;
    m_clear();
    chk("midrst_ready", bus.o_cmd_ready, 1);
    chk("midrst_status", bus.o_resp_status, 0);
    repeat (2*D + 4) begin @(posedge i_clk); #1; if (bus.o_resp_valid) seen++; end
    chk("midrst_no_resp", seen, 0);
    chk_books("midrst");
    do_cmd(1, 1, 0, 101, 0, 0);
    chk("midrst_gone", bus.o_resp_status, 2);

    for (int n = 0; n < 250; n++) begin
      rr = $urandom_range(0, 9);
      op = (rr < 5) ? 0 : (rr < 7) ? 1 : (rr < 9) ? 2 : 3;
      do_cmd(op, $urandom_range(0, 1), $urandom_range(0, NS-1), $urandom_range(0, 23),
             ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(1, 300),
             QW'($urandom_range(0, 30)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/order_book_scan.md
# order_book_scan

Parametrised order book for up to NUM_STOCKS instruments with separate buy/sell slot arrays per stock. It accepts ADD / CANCEL / EXECUTE commands by order ID over a valid/ready handshake and returns a status plus quantity per command. It recomputes best bid and best ask for the affected stock by full rescan, and presents registered top-of-book for every stock to downstream trading logic. It sits between the feed decoder and the strategy block.

## Interface
- NUM_STOCKS, 4, number of instruments (≥1)
- DEPTH, 16, order slots per stock per side (≥2)
- PRICE_W, 32, price width (unsigned)
- QTY_W, 16, quantity width (unsigned)
- ID_W, 32, order ID width
- SID_W, $clog2(NUM_STOCKS) (min 1), stock ID width (derived localparam)

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  synchronous, active-low reset
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  block can accept a command
- i_cmd_op  in  2  0 ADD, 1 CANCEL, 2 EXECUTE, 3 reserved
- i_cmd_side  in  1  1 buy, 0 sell
- i_cmd_stock  in  SID_W  target stock
- i_cmd_id  in  ID_W  order ID
- i_cmd_price  in  PRICE_W  price (ADD only)
- i_cmd_qty  in  QTY_W  quantity (ADD: size; EXECUTE: fill size)
- o_resp_valid  out  1  one-cycle response pulse, no backpressure
- o_resp_status  out  2  0 OK, 1 FULL, 2 NOT_FOUND, 3 DUP_ID
- o_resp_qty  out  QTY_W  ADD: qty stored; CANCEL: qty removed; EXECUTE: qty filled; 0 on error
- o_best_bid  out  NUM_STOCKS*PRICE_W  max valid buy price per stock; stock s at [s*PRICE_W +: PRICE_W]; 0 when empty
- o_best_ask  out  NUM_STOCKS*PRICE_W  min valid sell price per stock; all-ones when empty

## Operation
- Storage: NUM_STOCKS×2×DEPTH slots, each {valid, id, price, qty}.
- Handshake: command captured at the rising edge where i_cmd_valid && o_cmd_ready. o_cmd_ready is high only in IDLE and RESP.
- States: IDLE → SEARCH → APPLY → RESCAN → RESP → IDLE, or → SEARCH directly from RESP when a new command is accepted there.
- SEARCH: visit slot index 0..DEPTH-1 of the (stock, side) array, one per cycle. Record the first valid slot with matching id and the lowest-index free slot. Always takes exactly DEPTH cycles.
- APPLY, one cycle:
  - ADD: id match → DUP_ID, no write. No free slot → FULL. Otherwise write {1, id, price, qty} to the lowest free slot, status OK, resp qty = qty.
  - CANCEL: no match → NOT_FOUND. Otherwise clear valid, resp qty = stored qty.
  - EXECUTE: no match → NOT_FOUND. Otherwise fill = min(i_cmd_qty, stored qty) and stored qty -= fill. Clear the slot when the remainder reaches 0. resp qty = fill.
  - EXECUTE with i_cmd_qty = 0 → OK, fill 0, no change.
  - Op 3: NOT_FOUND, no change.
- RESCAN: DEPTH cycles over the post-APPLY array of the same (stock, side), computing max (buy) or min (sell) of valid prices. Runs even on error. Empty result gives 0 (bid) or all-ones (ask).
- RESP: o_resp_valid = 1. The best bid/ask register for the affected stock and side loads the rescan result on the same edge. Other stocks and sides are unchanged.
- Price comparisons are unsigned, full PRICE_W. Quantity subtraction never underflows, because fill ≤ stored.
- IDs are unique only per (stock, side): the same id may exist on the other side or another stock.

## Timing
- Reset (i_reset_n low at an edge):
  - all slot valid bits cleared, state IDLE
  - o_cmd_ready = 1 from the first cycle after reset deasserts
  - o_resp_valid = 0, o_resp_status = 0, o_resp_qty = 0
  - o_best_bid all 0, o_best_ask all ones
- Reset mid-command: the command is aborted and no response is issued.
- Latency: command accepted at edge E0 → o_resp_valid high in the cycle after edge E0 + 2·DEPTH + 1.
  - For DEPTH=16, response after 33 edges.
  - Back-to-back throughput is one command per 2·DEPTH+2 cycles.
- o_best_* change only on the edge entering RESP.
- o_resp_status and o_resp_qty hold their value until the next RESP.
- i_cmd_* are don't-care when not accepted. All inputs are registered at accept; changes after accept have no effect.

## Test plan
- Reset, then ADD buy stock 1 id 0xA price 100 qty 50 → OK, qty 50. bid[1] = 100; ask[1] = 0xFFFFFFFF; other stocks untouched.
- ADD buy stock 1 ids 0xB @120 and 0xC @90, then CANCEL 0xB → OK qty removed, bid[1] = 100. CANCEL 0xB again → NOT_FOUND, qty 0.
- ADD sell stock 2 id 5 @200 qty 10. EXECUTE id 5 qty 4 → OK fill 4. EXECUTE id 5 qty 9 → OK fill 6, slot freed, ask[2] = all-ones.
- Fill all DEPTH buy slots of stock 0 → (DEPTH+1)th ADD → FULL. CANCEL slot 3's id, then ADD → OK, lands in slot 3.
- ADD duplicate id on the same stock/side → DUP_ID, book unchanged. The same id on the opposite side → OK.
- Drive i_cmd_valid continuously with 3 commands → ready pulses only in IDLE/RESP, response spacing is 2·DEPTH+2 cycles. Assert reset during RESCAN → no response, all books empty afterwards.
